rvfi_trace_fifo: RTL and testbench

Retirement-trace buffer downstream of the RVFI packer. Each cycle it takes up to NrCommitPorts retired-instruction records and serialises them, in program order, into a single valid/ready stream for the trace sink (tracer, DPI bridge or debug trace port). Every record carries a 64-bit order number. Records that cannot be buffered are dropped atomically per cycle and counted, so the sink can detect gaps.

---
 rtl/rvfi_trace_fifo.sv | 93 +++++++++
 tb/tb_rvfi_trace_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: serialises multi-port RVFI retirement records into one ordered trace stream
module rvfi_trace_fifo #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned RecordWidth   = 512,
    parameter int unsigned Depth         = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NrCommitPorts-1:0]               rvfi_valid_i,
    input  logic [NrCommitPorts*RecordWidth-1:0]   rvfi_record_i,
    output logic                                   trace_valid_o,
    input  logic                                   trace_ready_i,
    output logic [RecordWidth-1:0]                 trace_record_o,
    output logic [63:0]                            trace_order_o,
    output logic [$clog2(Depth):0]                 fill_level_o,
    output logic [31:0]                            drop_count_o,
    output logic                                   overflow_o,
    input  logic                                   clear_i
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [RecordWidth-1:0] mem_rec [Depth];
    logic [63:0]            mem_ord [Depth];
    logic [CW-1:0]          count_q, count_d, n_valid, free;
    logic [CW-1:0]          off [NrCommitPorts];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]            order_q, order_d;
    logic [31:0]            drop_q, drop_d;
    logic [32:0]            drop_sum;
    logic                   ovf_q, ovf_d, accept, pop;

    // count valid ports; each valid port's slot offset is the number of valid ports below it
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            off[i]  = n_valid;
            n_valid = n_valid + CW'(rvfi_valid_i[i]);
        end
    end

    // accept uses start-of-cycle occupancy only, so ready never reaches this decision
    assign free   = CW'(Depth) - count_q;
    assign accept = n_valid <= free;
    assign pop    = (count_q != '0) && trace_ready_i;

    // next-state for pointers, occupancy, order and drop accounting
    always_comb begin
        count_d  = count_q + (accept ? n_valid : '0) - CW'(pop);
        wr_ptr_d = wr_ptr_q + (accept ? AW'(n_valid) : '0);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        order_d  = order_q + 64'(n_valid);
        drop_sum = 33'(clear_i ? 32'd0 : drop_q) + (accept ? 33'd0 : 33'(n_valid));
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
        ovf_d    = (ovf_q & ~clear_i) | ~accept;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            order_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            order_q  <= order_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // write accepted records compressed into consecutive slots; storage is not reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrCommitPorts; i++) begin
            if (accept && rvfi_valid_i[i]) begin
                mem_rec[wr_ptr_q + AW'(off[i])] <= rvfi_record_i[i*RecordWidth +: RecordWidth];
                mem_ord[wr_ptr_q + AW'(off[i])] <= order_q + 64'(off[i]);
            end
        end
    end

    assign trace_valid_o  = count_q != '0;
    assign trace_record_o = mem_rec[rd_ptr_q];
    assign trace_order_o  = mem_ord[rd_ptr_q];
    assign fill_level_o   = count_q;
    assign drop_count_o   = drop_q;
    assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// tb_rvfi_trace_fifo: directed and scoreboarded checks of the retirement trace FIFO
module tb_rvfi_trace_fifo;
    localparam int RW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    valid = '0;
    logic [RW-1:0] rec0 = '0, rec1 = '0;
    logic          ready = 1'b0;
    logic          clear = 1'b0;
    logic          t_valid, ovf;
    logic [RW-1:0] t_rec;
    logic [63:0]   t_ord;
    logic [3:0]    fill;
    logic [31:0]   drop;
    int            vectors = 0;
    int            miscompares = 0;

    typedef struct {
        logic [63:0]   ord;
        logic [RW-1:0] rec;
    } ent_t;

    rvfi_trace_fifo dut (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_record_i({rec1, rec0}),
        .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_record_o(t_rec),
        .trace_order_o(t_ord), .fill_level_o(fill), .drop_count_o(drop),
        .overflow_o(ovf), .clear_i(clear)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mk(input int n);
        mk = {16{32'(n) + 32'hC0DE_0000}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] v, input int base);
        valid = v;
        rec0  = v[0] ? mk(base) : ~mk(base);
        rec1  = mk(v[0] ? base + 1 : base);
    endtask

    task automatic do_reset();
        valid = '0;
        rst   = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        ent_t        q[$];
        ent_t        e;
        logic [1:0]  v;
        logic        r, pop, acc, have_last;
        logic [63:0] last, mord;
        int          offered, drops, nv, k;

        do_reset();
        chk("rst_valid", 64'(t_valid), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        ready = 1'b1;
        push(2'b01, 0);
        tick();
        valid = '0;
        chk("single_valid", 64'(t_valid), 64'd1);
        chk_rec("single_rec", t_rec, mk(0));
        chk("single_ord", t_ord, 64'd0);
        tick();
        chk("single_empty", 64'(t_valid), 64'd0);
        chk("single_fill", 64'(fill), 64'd0);

        do_reset();
        ready = 1'b1;
        push(2'b11, 0);
        tick();
        chk_rec("dual_a_rec", t_rec, mk(0));
        chk("dual_a_ord", t_ord, 64'd0);
        push(2'b10, 2);
        tick();
        valid = '0;
        chk_rec("dual_b_rec", t_rec, mk(1));
        chk("dual_b_ord", t_ord, 64'd1);
        tick();
        chk_rec("dual_c_rec", t_rec, mk(2));
        chk("dual_c_ord", t_ord, 64'd2);
        tick();
        chk("dual_empty", 64'(t_valid), 64'd0);

        do_reset();
        ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push(2'b11, 2 * c);
            tick();
        end
        chk("ovf_fill8", 64'(fill), 64'd8);
        chk("ovf_nodrop", 64'(drop), 64'd0);
        push(2'b11, 8);
        tick();
        valid = '0;
        chk("ovf_fill_hold", 64'(fill), 64'd8);
        chk("ovf_drop", 64'(drop), 64'd2);
        chk("ovf_flag", 64'(ovf), 64'd1);
        ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("ovf_drain_ord", t_ord, 64'(j));
            chk_rec("ovf_drain_rec", t_rec, mk(j));
            tick();
        end
        chk("ovf_drained", 64'(fill), 64'd0);
        push(2'b01, 10);
        tick();
        valid = '0;
        chk("ovf_gap_ord", t_ord, 64'd10);
        chk_rec("ovf_gap_rec", t_rec, mk(10));
        tick();

        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            push(2'b11, 11 + 2 * c);
            tick();
        end
        push(2'b01, 17);
        tick();
        chk("bnd_fill7", 64'(fill), 64'd7);
        push(2'b11, 18);
        ready = 1'b1;
        tick();
        valid = '0;
        chk("bnd_fill6", 64'(fill), 64'd6);
        chk("bnd_drop", 64'(drop), 64'd4);
        chk("bnd_head", t_ord, 64'd12);
        for (int j = 12; j < 18; j++) begin
            chk("bnd_drain_ord", t_ord, 64'(j));
            chk_rec("bnd_drain_rec", t_rec, mk(j));
            tick();
        end
        chk("bnd_empty", 64'(t_valid), 64'd0);

        ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push(2'b11, 20 + 2 * c);
            tick();
        end
        push(2'b01, 28);
        clear = 1'b1;
        tick();
        valid = '0;
        chk("clr_drop1", 64'(drop), 64'd1);
        chk("clr_ovf1", 64'(ovf), 64'd1);
        tick();
        clear = 1'b0;
        chk("clr_drop0", 64'(drop), 64'd0);
        chk("clr_ovf0", 64'(ovf), 64'd0);
        chk("clr_fill", 64'(fill), 64'd8);
        ready = 1'b1;
        tick();
        tick();
        tick();
        ready = 1'b0;
        chk("clr_fill5", 64'(fill), 64'd5);
        chk("clr_head", t_ord, 64'd23);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst5_valid", 64'(t_valid), 64'd0);
        chk("rst5_fill", 64'(fill), 64'd0);
        push(2'b01, 0);
        tick();
        valid = '0;
        chk("rst5_ord", t_ord, 64'd0);
        chk("rst5_vld", 64'(t_valid), 64'd1);

        do_reset();
        offered   = 0;
        drops     = 0;
        mord      = '0;
        have_last = 1'b0;
        last      = '0;
        for (int cyc = 0; cyc < 400 && (offered < 40 || q.size() > 0); cyc++) begin
            v     = (offered < 40) ? 2'($urandom_range(0, 3)) : 2'b00;
            r     = ($urandom_range(0, 2) != 0);
            valid = v;
            ready = r;
            rec0  = mk(1000 + 2 * cyc);
            rec1  = mk(1001 + 2 * cyc);
            chk("rnd_fill", 64'(fill), 64'(q.size()));
            chk("rnd_valid", 64'(t_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_ord", t_ord, q[0].ord);
                chk_rec("rnd_rec", t_rec, q[0].rec);
                if (have_last)
                    chk("rnd_mono", 64'(t_ord > last), 64'd1);
            end
            pop = (q.size() > 0) && r;
            nv  = $countones(v);
            acc = nv <= 8 - q.size();
            tick();
            if (pop) begin
                last      = q[0].ord;
                have_last = 1'b1;
                void'(q.pop_front());
            end
            k = 0;
            if (acc) begin
                if (v[0]) begin
                    e.ord = mord;
                    e.rec = mk(1000 + 2 * cyc);
                    q.push_back(e);
                    k++;
                end
                if (v[1]) begin
                    e.ord = mord + 64'(k);
                    e.rec = mk(1001 + 2 * cyc);
                    q.push_back(e);
                end
            end else begin
                drops += nv;
            end
            mord    += 64'(nv);
            offered += nv;
        end
        valid = '0;
        ready = 1'b0;
        chk("rnd_drained", 64'(fill), 64'd0);
        chk("rnd_drops", 64'(drop), 64'(drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
